control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/mcu_pkg.sv | 38 +++
 rtl/instr_decode.sv | 63 ++++++
 rtl/control_unit.sv | 192 +++++++++++++++++++
 tb/tb_control_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the small MCU control path.
//   - 4-bit opcode encodings (OP_NOP .. OP_JMP)
//   - ALU B-operand source encodings
//   - control unit FSM state type
package mcu_pkg;

  // Opcodes, instruction bits [15:12]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_LDI   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_IN    = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_BZ    = 4'hB;
  localparam logic [3:0] OP_BNZ   = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hE;
  localparam logic [3:0] OP_JMP   = 4'hF;

  // ALU B operand mux select
  localparam logic [1:0] BSRC_REG  = 2'b00;
  localparam logic [1:0] BSRC_IMM  = 2'b01;
  localparam logic [1:0] BSRC_PORT = 2'b10;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } cu_state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction field and class decode.
// Format: [15:12] op, [11:10] rd, [9:8] ra, [7:6] rb, [7:0] imm, [2:0] sh.
// Ports:
//   ir_i        instruction word
//   op_o .. sh_o  raw fields
//   b_src_o     ALU B operand select for this op
//   wb_class_o  op writes the register file and updates the flags
//   store_o     data-store op
//   jmp_o, bz_o, bnz_o  control-transfer ops
module instr_decode
  import mcu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [3:0]  op_o,
  output logic [1:0]  rd_o,
  output logic [1:0]  ra_o,
  output logic [1:0]  rb_o,
  output logic [7:0]  imm_o,
  output logic [2:0]  sh_o,
  output logic [1:0]  b_src_o,
  output logic        wb_class_o,
  output logic        store_o,
  output logic        jmp_o,
  output logic        bz_o,
  output logic        bnz_o
);

  // imm and rb/sh overlap by design; the op decides which field matters.
  assign op_o  = ir_i[15:12];
  assign rd_o  = ir_i[11:10];
  assign ra_o  = ir_i[9:8];
  assign rb_o  = ir_i[7:6];
  assign imm_o = ir_i[7:0];
  assign sh_o  = ir_i[2:0];

  always_comb begin
    b_src_o    = BSRC_REG;
    wb_class_o = 1'b0;
    store_o    = 1'b0;
    jmp_o      = 1'b0;
    bz_o       = 1'b0;
    bnz_o      = 1'b0;
    unique case (op_o)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
        wb_class_o = 1'b1;
      end
      OP_LDI, OP_SUBI, OP_ADDI: begin
        wb_class_o = 1'b1;
        b_src_o    = BSRC_IMM;
      end
      OP_IN: begin
        wb_class_o = 1'b1;
        b_src_o    = BSRC_PORT;
      end
      OP_BZ:    bz_o    = 1'b1;
      OP_BNZ:   bnz_o   = 1'b1;
      OP_STORE: store_o = 1'b1;
      OP_JMP:   jmp_o   = 1'b1;
      OP_NOP, OP_HALT: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Optional feature: define CU_HALT_EN to make op 1110 enter a terminal HALT
// state (otherwise op 1110 is a NOP and halted is tied low).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata  instruction fetch handshake, addr = pc
//   zero, neg           ALU flags, combinational from fs/operands
//   fs, sh              ALU function select (op in EXECUTE) and shift amount
//   ra/rb/rd_addr       register file selects
//   b_src, imm          ALU B operand select and immediate
//   reg_we, mem_we      one-cycle write strobes in WRITEBACK
//   halted              control unit is in HALT
module control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            zero,
  input  logic            neg,
  output logic [3:0]      fs,
  output logic [2:0]      sh,
  output logic [1:0]      ra_addr,
  output logic [1:0]      rb_addr,
  output logic [1:0]      rd_addr,
  output logic [1:0]      b_src,
  output logic [7:0]      imm,
  output logic            reg_we,
  output logic            mem_we,
  output logic            halted
);

  cu_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            z_q, z_d;
  logic            n_q, n_d;
  // Low for the first cycle after reset so imem_req only rises on the first edge.
  logic            run_q;

  logic [3:0] op_dec;
  logic [1:0] rd_dec, ra_dec, rb_dec, b_src_dec;
  logic [7:0] imm_dec;
  logic [2:0] sh_dec;
  logic       wb_class, is_store, is_jmp, is_bz, is_bnz;
  logic       take_branch;
  logic       fetch_done;

  instr_decode u_decode (
    .ir_i       (ir_q),
    .op_o       (op_dec),
    .rd_o       (rd_dec),
    .ra_o       (ra_dec),
    .rb_o       (rb_dec),
    .imm_o      (imm_dec),
    .sh_o       (sh_dec),
    .b_src_o    (b_src_dec),
    .wb_class_o (wb_class),
    .store_o    (is_store),
    .jmp_o      (is_jmp),
    .bz_o       (is_bz),
    .bnz_o      (is_bnz)
  );

  assign fetch_done  = (state_q == StFetch) && run_q && imem_ack;
  assign take_branch = is_jmp | (is_bz & z_q) | (is_bnz & ~z_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:     if (fetch_done) state_d = StDecode;
      StDecode:    state_d = StExecute;
      StExecute:   state_d = StWriteback;
      StWriteback: begin
`ifdef CU_HALT_EN
        if (op_dec == OP_HALT) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
`else
        state_d = StFetch;
`endif
      end
      StHalt:      state_d = StHalt;
      default:     state_d = StFetch;
    endcase
  end

  // Datapath registers: pc, ir, flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      run_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      z_q   <= z_d;
      n_q   <= n_d;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    z_d  = z_q;
    n_d  = n_q;
    if (fetch_done) begin
      ir_d = imem_rdata;
    end
    if ((state_q == StExecute) && wb_class) begin
      z_d = zero;
      n_d = neg;
    end
    if (state_q == StWriteback) begin
      // Natural wrap modulo 2^PC_W on the increment.
      pc_d = take_branch ? PC_W'(imm_dec) : pc_q + PC_W'(1);
    end
  end

  // Output logic
  assign imem_addr = pc_q;

  always_comb begin
    imem_req = 1'b0;
    fs       = 4'b0000;
    sh       = '0;
    ra_addr  = '0;
    rb_addr  = '0;
    rd_addr  = '0;
    b_src    = BSRC_REG;
    imm      = '0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    if (state_q == StFetch) begin
      imem_req = run_q;
    end
    // Decoded fields are visible from DECODE and held through WRITEBACK.
    if ((state_q == StDecode) || (state_q == StExecute) || (state_q == StWriteback)) begin
      sh      = sh_dec;
      ra_addr = ra_dec;
      rb_addr = rb_dec;
      rd_addr = rd_dec;
      b_src   = b_src_dec;
      imm     = imm_dec;
    end
    if (state_q == StExecute) begin
      fs = op_dec;
    end
    if (state_q == StWriteback) begin
      reg_we = wb_class;
      mem_we = is_store;
    end
  end

`ifdef CU_HALT_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

  // Flags may only move on the edge that ends EXECUTE.
  a_flags_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != StExecute) |=> $stable({z_q, n_q}));

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(reg_we && mem_we));

  a_halt_no_fetch: assert property (@(posedge clk) disable iff (!rst_n)
    halted |-> !imem_req);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table of single instructions with
// hand-computed outcomes, plus directed sequences for fetch stall, reset
// during EXECUTE and op 1110 (HALT when CU_HALT_EN is defined, NOP otherwise).
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        zero;
  logic        neg;
  logic [3:0]  fs;
  logic [2:0]  sh;
  logic [1:0]  ra_addr;
  logic [1:0]  rb_addr;
  logic [1:0]  rd_addr;
  logic [1:0]  b_src;
  logic [7:0]  imm;
  logic        reg_we;
  logic        mem_we;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] pc_cur;

  control_unit #(
    .PC_W     (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .zero       (zero),
    .neg        (neg),
    .fs         (fs),
    .sh         (sh),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .rd_addr    (rd_addr),
    .b_src      (b_src),
    .imm        (imm),
    .reg_we     (reg_we),
    .mem_we     (mem_we),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        z;
    logic        n;
    logic [1:0]  bsrc;
    logic        rwe;
    logic        mwe;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH; checks every cycle of it.
  task automatic run_instr(input logic [15:0] instr, input int ack_delay, input logic z,
                           input logic n, input logic [1:0] exp_bsrc, input logic exp_rwe,
                           input logic exp_mwe, input logic [7:0] exp_pc, input bit to_fetch,
                           input string tag);
    logic [22:0] exp_fields;
    exp_fields = {instr[9:8], instr[7:6], instr[11:10], instr[7:0], instr[2:0], exp_bsrc};
    imem_rdata = instr;
    imem_ack   = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      chk({tag, " stall req"}, 64'(imem_req), 64'(1'b1));
      chk({tag, " stall addr"}, 64'(imem_addr), 64'(pc_cur));
      step();
    end
    imem_ack = 1'b1;
    chk({tag, " fetch req"}, 64'(imem_req), 64'(1'b1));
    chk({tag, " fetch addr"}, 64'(imem_addr), 64'(pc_cur));
    step();
    imem_ack   = 1'b0;
    imem_rdata = ~instr;
    // DECODE
    chk({tag, " decode fields"}, 64'({ra_addr, rb_addr, rd_addr, imm, sh, b_src}),
        64'(exp_fields));
    chk({tag, " decode fs/req"}, 64'({fs, imem_req}), 64'(5'b0));
    step();
    // EXECUTE
    zero = z;
    neg  = n;
    chk({tag, " exec fs"}, 64'(fs), 64'(instr[15:12]));
    chk({tag, " exec b_src"}, 64'(b_src), 64'(exp_bsrc));
    chk({tag, " exec strobes"}, 64'({reg_we, mem_we}), 64'(2'b00));
    step();
    // WRITEBACK; flip the flags so a late latch would be visible later
    zero = ~z;
    neg  = ~n;
    chk({tag, " wb strobes"}, 64'({reg_we, mem_we}), 64'({exp_rwe, exp_mwe}));
    chk({tag, " wb fs"}, 64'(fs), 64'(4'b0000));
    chk({tag, " wb fields"}, 64'({ra_addr, rb_addr, rd_addr, imm, sh, b_src}),
        64'(exp_fields));
    step();
    zero   = 1'b0;
    neg    = 1'b0;
    pc_cur = exp_pc;
    if (to_fetch) begin
      chk({tag, " next pc"}, 64'(imem_addr), 64'(exp_pc));
      chk({tag, " next req"}, 64'(imem_req), 64'(1'b1));
      chk({tag, " next strobes"}, 64'({reg_we, mem_we}), 64'(2'b00));
    end
  endtask

  initial begin
    // instr, z, n, b_src, reg_we, mem_we, pc after
    vecs[0]  = '{16'hA405, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h01}; // ADDI r1,r0,5
    vecs[1]  = '{16'h2940, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h02}; // SUB -> z_flag=1
    vecs[2]  = '{16'hB040, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h40}; // BZ taken
    vecs[3]  = '{16'hC010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h41}; // BNZ not taken
    vecs[4]  = '{16'hD0C3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 8'h42}; // STORE, flags kept
    vecs[5]  = '{16'hB080, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h80}; // BZ still taken
    vecs[6]  = '{16'h4000, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'h81}; // OR -> z_flag=0
    vecs[7]  = '{16'hB020, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h82}; // BZ not taken
    vecs[8]  = '{16'hC033, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h33}; // BNZ taken
    vecs[9]  = '{16'h8000, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 8'h34}; // IN -> z_flag=1
    vecs[10] = '{16'h6007, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h35}; // LDI -> z_flag=0
    vecs[11] = '{16'h0000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h36}; // NOP
    vecs[12] = '{16'hF0FF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'hFF}; // JMP FF
    vecs[13] = '{16'h0000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00}; // NOP wraps pc
    vecs[14] = '{16'h7005, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h01}; // SHL sh=5
    vecs[15] = '{16'h9455, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h02}; // SUBI -> z_flag=0

    rst_n      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    zero       = 1'b0;
    neg        = 1'b0;
    pc_cur     = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset outputs", 64'({imem_req, imem_addr, fs, sh, ra_addr, rb_addr, rd_addr, b_src,
                              imm, reg_we, mem_we, halted}), 64'(0));
    repeat (2) step();
    rst_n = 1'b1;
    chk("req before first edge", 64'(imem_req), 64'(1'b0));
    step();
    chk("req on first edge", 64'(imem_req), 64'(1'b1));
    chk("reset pc", 64'(imem_addr), 64'(8'h00));

    for (int v = 0; v < 16; v++) begin
      run_instr(vecs[v].instr, 0, vecs[v].z, vecs[v].n, vecs[v].bsrc, vecs[v].rwe,
                vecs[v].mwe, vecs[v].pc, 1'b1, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d halted", v), 64'(halted), 64'(1'b0));
    end

    // ADD with ack three cycles late: 4 request cycles, 7 cycles total; z_flag=1
    run_instr(16'h1D80, 3, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'h03, 1'b1, "stall3");

    // Reset during EXECUTE of an ADD: instruction abandoned
    imem_rdata = 16'h1D80;
    imem_ack   = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    chk("rst-mid exec fs", 64'(fs), 64'(4'h1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst-mid async", 64'({reg_we, mem_we, fs, rd_addr, imem_req, imem_addr}), 64'(0));
    step();
    chk("rst-mid no reg_we", 64'({reg_we, mem_we}), 64'(2'b00));
    step();
    rst_n = 1'b1;
    chk("rst-mid req low", 64'(imem_req), 64'(1'b0));
    step();
    chk("rst-mid refetch req", 64'(imem_req), 64'(1'b1));
    chk("rst-mid pc", 64'(imem_addr), 64'(8'h00));
    pc_cur = 8'h00;
    // z_flag was 1 before reset; a cleared flag makes this BZ fall through
    run_instr(16'hB040, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h01, 1'b1, "post-rst bz");
    run_instr(16'h0000, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h02, 1'b1, "post-rst nop");

`ifdef CU_HALT_EN
    run_instr(16'hE000, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h03, 1'b0, "halt");
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("halt c%0d halted", c), 64'(halted), 64'(1'b1));
      chk($sformatf("halt c%0d req", c), 64'({imem_req, reg_we, mem_we}), 64'(3'b000));
      step();
    end
`else
    run_instr(16'hE000, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h03, 1'b1, "op1110 nop");
    chk("op1110 halted", 64'(halted), 64'(1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
